// File: rtl/regbank_wr_arbiter_if.sv
// Write-side bus between the writeback requesters and the register bank.
//   req/req_dr/req_data : per-requester write requests (NREQ slices)
//   gnt                 : one-hot grant back to the requesters (combinational)
//   write/dr/wrData     : registered write port into the register bank
// The slave modport is the arbiter; the master modport is the requester side.
interface regbank_wr_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_dr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               write;
  logic [AW-1:0]      dr;
  logic [DW-1:0]      wrData;

  modport slave (
    input  req, req_dr, req_data,
    output gnt, write, dr, wrData
  );

  modport master (
    output req, req_dr, req_data,
    input  gnt, write, dr, wrData
  );
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter for the single write port of the 32x32 register bank,
// with a sequenced clear (one register per cycle) and R0 write suppression.
// Ports:
//   clk, reset (async, active-low)
//   bus          : regbank_wr_arbiter_if.slave (requests in, grant and write port out)
//   clr_start    : one-cycle pulse that starts the clear sequence
//   clr_busy     : high while the clear sequence runs
//   clr_done     : one-cycle pulse after the final clear write
//   contend_cnt  : saturating count of contended IDLE cycles
//                  (present only when REGBANK_WR_CONTEND_CNT_EN is defined)
module regbank_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  regbank_wr_arbiter_if.slave      bus,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done
`ifdef REGBANK_WR_CONTEND_CNT_EN
  ,
  output logic [15:0]              contend_cnt
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          write_q, write_d;
  logic [AW-1:0] dr_q, dr_d;
  logic [DW-1:0] data_q, data_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_c;
  logic [AW-1:0]   sel_dr;
  logic [DW-1:0]   sel_data;
  logic            arb_en;
  int unsigned     rr_idx;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = 32'(ptr_q) + k;
      if (rr_idx >= NREQ) begin
        rr_idx = rr_idx - NREQ;
      end
      if (!gnt_any && bus.req[PW'(rr_idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(rr_idx);
      end
    end
  end

  // Grant only while idle, out of reset, and not yielding to a clear start.
  assign arb_en = reset && (state_q == S_IDLE) && !clr_start && gnt_any;

  // One-hot grant and the selected requester's payload.
  always_comb begin
    gnt_c    = '0;
    sel_dr   = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == gnt_idx) begin
        gnt_c[k] = arb_en;
        sel_dr   = bus.req_dr[k*AW +: AW];
        sel_data = bus.req_data[k*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    write_d = 1'b0;
    dr_d    = dr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else if (gnt_any) begin
          // A request to R0 is consumed but never reaches the bank.
          write_d = (sel_dr != '0);
          dr_d    = sel_dr;
          data_d  = sel_data;
          ptr_d   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
        end
      end
      S_CLEAR: begin
        write_d = 1'b1;
        dr_d    = cnt_q;
        data_d  = '0;
        if (cnt_q == '1) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      dr_q    <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      dr_q    <= dr_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.write  = write_q;
  assign bus.dr     = dr_q;
  assign bus.wrData = data_q;
  assign clr_busy   = busy_q;
  assign clr_done   = done_q;

`ifdef REGBANK_WR_CONTEND_CNT_EN
  logic [3:0]  req_cnt_c;
  logic [15:0] contend_q, contend_d;

  // Saturating count of idle cycles with two or more requests pending.
  always_comb begin
    req_cnt_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_cnt_c = req_cnt_c + 4'(bus.req[k]);
    end
    contend_d = contend_q;
    if ((state_q == S_IDLE) && (req_cnt_c >= 4'd2) && (contend_q != 16'hFFFF)) begin
      contend_d = contend_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contend_q <= '0;
    end else begin
      contend_q <= contend_d;
    end
  end

  assign contend_cnt = contend_q;
`endif

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
module tb_regbank_wr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_start = 1'b0;
  logic clr_busy, clr_done;
`ifdef REGBANK_WR_CONTEND_CNT_EN
  logic [15:0] contend_cnt;
`endif

  always #5 clk = ~clk;

  regbank_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regbank_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
`ifdef REGBANK_WR_CONTEND_CNT_EN
    ,
    .contend_cnt (contend_cnt)
`endif
  );

  typedef struct packed {
    logic        wr;
    logic [4:0]  dr;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int          ptr_m   = 0;
  bit          clear_m = 1'b0;
  int          cnt_m   = 0;
  logic [4:0]  dr_m    = '0;
  logic [31:0] data_m  = '0;
  bit          auto_drop = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] v);
    bus.req_dr[i*AW +: AW]   = d;
    bus.req_data[i*DW +: DW] = v;
  endtask

  // One clock: predict grant, push expected write-port result, compare after the edge.
  task automatic step(input string tag);
    logic [NREQ-1:0] eg;
    int   sel;
    exp_t e;
    exp_t got;
    eg  = '0;
    sel = -1;
    if (!clear_m && !clr_start) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ptr_m + k) % NREQ;
        if (sel < 0 && bus.req[idx]) sel = idx;
      end
    end
    if (sel >= 0) eg[sel] = 1'b1;
    #1;
    chk({tag, ":gnt"}, 64'(bus.gnt), 64'(eg));
    e.done = 1'b0;
    if (clear_m) begin
      e.wr = 1'b1; e.dr = cnt_m[4:0]; e.data = '0;
      dr_m = e.dr; data_m = '0;
      if (cnt_m == 31) begin clear_m = 1'b0; e.done = 1'b1; end
      else cnt_m++;
    end else if (clr_start) begin
      clear_m = 1'b1; cnt_m = 0;
      e.wr = 1'b0; e.dr = dr_m; e.data = data_m;
    end else if (sel >= 0) begin
      dr_m   = bus.req_dr[sel*AW +: AW];
      data_m = bus.req_data[sel*DW +: DW];
      e.wr = (dr_m != 5'd0); e.dr = dr_m; e.data = data_m;
      ptr_m = (sel + 1) % NREQ;
    end else begin
      e.wr = 1'b0; e.dr = dr_m; e.data = data_m;
    end
    e.busy = clear_m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk({tag, ":write"},  64'(bus.write),  64'(got.wr));
    chk({tag, ":dr"},     64'(bus.dr),     64'(got.dr));
    chk({tag, ":wrData"}, 64'(bus.wrData), 64'(got.data));
    chk({tag, ":busy"},   64'(clr_busy),   64'(got.busy));
    chk({tag, ":done"},   64'(clr_done),   64'(got.done));
    if (auto_drop) bus.req = bus.req & ~eg;
    @(negedge clk);
  endtask

  initial begin
    bus.req      = '0;
    bus.req_dr   = '0;
    bus.req_data = '0;

    // Reset: outputs at reset values, no grant even with a request pending
    bus.req = 3'b001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #3;
    chk("rst:gnt",    64'(bus.gnt),    64'd0);
    chk("rst:write",  64'(bus.write),  64'd0);
    chk("rst:dr",     64'(bus.dr),     64'd0);
    chk("rst:wrData", 64'(bus.wrData), 64'd0);
    chk("rst:busy",   64'(clr_busy),   64'd0);
    chk("rst:done",   64'(clr_done),   64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single request from requester 0
    step("single");
    step("idle0");

    // All three requesting, each drops after its grant
    set_req(0, 5'd1, 32'h1111_0000);
    set_req(1, 5'd2, 32'h2222_0000);
    set_req(2, 5'd3, 32'h3333_0000);
    bus.req = 3'b111;
    step("rr0");
    step("rr1");
    step("rr2");
    step("idle1");

    // Write to R0 is consumed without a write pulse
    set_req(1, 5'd0, 32'h0000_1234);
    bus.req = 3'b010;
    step("r0");
    step("idle2");

    // Clear wins over a simultaneous request; request served afterwards
    set_req(2, 5'd7, 32'hCAFE_F00D);
    bus.req   = 3'b100;
    clr_start = 1'b1;
    step("clrstart");
    clr_start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c == 5) clr_start = 1'b1;
      step($sformatf("clr%0d", c));
      clr_start = 1'b0;
    end
    step("postclr");
    step("idle3");

    // Reset mid-clear aborts the sequence
    bus.req   = 3'b100;
    clr_start = 1'b1;
    step("clr2start");
    clr_start = 1'b0;
    for (int c = 0; c < 10; c++) step($sformatf("clr2_%0d", c));
    reset = 1'b0;
    #1;
    chk("abort:gnt",    64'(bus.gnt),    64'd0);
    chk("abort:write",  64'(bus.write),  64'd0);
    chk("abort:dr",     64'(bus.dr),     64'd0);
    chk("abort:wrData", 64'(bus.wrData), 64'd0);
    chk("abort:busy",   64'(clr_busy),   64'd0);
    chk("abort:done",   64'(clr_done),   64'd0);
    ptr_m = 0; clear_m = 1'b0; cnt_m = 0; dr_m = '0; data_m = '0;
    sbq.delete();
    bus.req = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) step($sformatf("postabort%0d", c));

`ifdef REGBANK_WR_CONTEND_CNT_EN
    // Contention counter: two requests held with no drops
    auto_drop = 1'b0;
    set_req(0, 5'd9,  32'h9);
    set_req(1, 5'd10, 32'hA);
    bus.req = 3'b011;
    for (int c = 0; c < 4; c++) step($sformatf("cont%0d", c));
    chk("contend4", 64'(contend_cnt), 64'd4);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("contend_sat", 64'(contend_cnt), 64'hFFFF);
    bus.req = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
- Shares the single write port of the 32x32 MIPS register bank among NREQ writeback requesters, using round-robin arbitration.
- Provides a sequenced clear that zeroes all 32 registers one per cycle.
- Enforces R0 as hardwired zero by suppressing writes to register 0.
- Sits between the writeback sources (ALU, load unit, debug port) and the register bank's write, dr and wrData inputs.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- AW, 5, register address width.
- DW, 32, write data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester write request; held high until granted.
- req_dr  input  NREQ*AW  destination register per requester; slice i = bits [i*AW +: AW].
- req_data  input  NREQ*DW  write data per requester; slice i = bits [i*DW +: DW].
- gnt  output  NREQ  one-hot grant, combinational; the transfer completes in the cycle gnt[i] is high.
- clr_start  input  1  1-cycle pulse; starts the clear sequence.
- clr_busy  output  1  high while the clear sequence runs.
- clr_done  output  1  1-cycle pulse after the final clear write.
- write  output  1  registered write enable to the register bank.
- dr  output  AW  registered write address to the register bank.
- wrData  output  DW  registered write data to the register bank.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; write=0, dr=0, wrData=0, clr_busy=0, clr_done=0; rr pointer=0; clear counter=0. gnt=0 while reset is low.
- States: IDLE, CLEAR.
- IDLE, arbitration:
  - If clr_start=0 and any req bit is high, gnt selects the first asserted req at or after index ptr, wrapping at NREQ-1 back to 0. Exactly one gnt bit is high.
  - On the next edge: write <= (granted req_dr != 0); dr <= granted req_dr; wrData <= granted req_data; ptr <= (granted index + 1) mod NREQ.
  - Latency: gnt in cycle N gives write=1 in cycle N+1. Back-to-back grants give one write per cycle.
  - A write request to dr=0 is granted and consumed, but write stays 0; dr and wrData still update.
  - No req: gnt=0; write <= 0; dr, wrData and ptr hold.
- IDLE to CLEAR, on clr_start=1:
  - gnt=0 that cycle; clr_start wins over simultaneous requests, which stay pending.
  - Next edge: state=CLEAR, clr_busy=1, cnt=0, write <= 0.
- CLEAR:
  - Each cycle gnt=0. On each edge: write <= 1, dr <= cnt, wrData <= 0, cnt <= cnt+1.
  - When cnt=31 is issued, the next edge gives state=IDLE, clr_busy=0, clr_done=1 for one cycle, write <= 0.
  - Total: 32 write pulses, dr = 0..31 ascending; the R0 write of zero is permitted here.
  - clr_start while in CLEAR is ignored; it does not restart the sequence.
  - Requests during CLEAR stay pending. Arbitration resumes in the first IDLE cycle, with ptr unchanged by the clear.
- Reset asserted mid-CLEAR aborts the sequence immediately. No clr_done is issued, and the remaining registers are not written.
- Arithmetic: cnt is AW bits and never wraps within a sequence. ptr is ceil(log2(NREQ)) bits with explicit mod-NREQ wrap; it never takes a value of NREQ or above.

Optional Feature:
- Macro: REGBANK_WR_CONTEND_CNT_EN.
- Defined:
  - Adds output port contend_cnt, 16 bits.
  - Increments on each IDLE cycle with two or more req bits high.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; not cleared by the clear sequence.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=3'b001, req_dr[0]=5, req_data[0]=32'hDEADBEEF: gnt=001 in the same cycle; next cycle write=1, dr=5, wrData=DEADBEEF; ptr=1.
- req=3'b111 held, each requester dropping req after its own grant: gnt sequence 001, 010, 100; write=1 for three consecutive cycles; dr values follow the same order.
- req=3'b010 with req_dr[1]=0, data 32'h1234: gnt=010; next cycle write=0, dr=0; requester released.
- clr_start pulse with req=3'b100 in the same cycle: gnt=0; clr_busy high for 32 cycles; write=1 with dr=0..31 and wrData=0; clr_done pulses once; then gnt=100 in the first IDLE cycle.
- Reset pulled low at clear cycle 10: all outputs return to reset values asynchronously; after release, state=IDLE, no clr_done, clr_busy=0.
- With REGBANK_WR_CONTEND_CNT_EN defined: req=3'b011 held for 4 cycles with no drops; contend_cnt=4. Preload near saturation and confirm it holds at FFFF.
